button_event_decoder: RTL and testbench

- Sits directly downstream of the debouncer and consumes its debounced_out level.
- Classifies each clean button gesture as short press, long press or double click.
- Emits one-cycle event pulses that the 7-segment mode/display controller uses to step counters, change modes, etc.
- Timing windows are given as clock-cycle counts; defaults assume the 50 MHz board clock.

---
 rtl/button_event_decoder.sv | 151 +++++++++++++++
 tb/tb_button_event_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle short/long/double-click event pulses.
// Optional auto-repeat while long-held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int DCLICK_CYCLES = 15000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > DCLICK_CYCLES)
                              ? ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES)
                              : ((DCLICK_CYCLES > REPEAT_CYCLES) ? DCLICK_CYCLES : REPEAT_CYCLES);

    if (CNT_W < $clog2(MAX_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured timing windows");
    end

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             btn_prev;
    logic             rise, fall;
    logic             short_nxt, long_nxt, dclick_nxt, tick_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rise = button_in & ~btn_prev;
    assign fall = ~button_in & btn_prev;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        dclick_nxt = 1'b0;
        tick_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESS1;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS1: begin
                if (button_in) begin
                    if (cnt == LONG_LAST) begin
                        long_nxt  = 1'b1;
                        state_nxt = LONG_HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end else if (fall) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT2: begin
                // A rise on the expiry cycle still wins as a double click.
                if (rise) begin
                    dclick_nxt = 1'b1;
                    state_nxt  = PRESS2;
                    cnt_nxt    = '0;
                end else if (cnt == DCLICK_LAST) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (button_in) begin
                    if (cnt == REPEAT_LAST) begin
                        tick_nxt = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // btn_prev resets high so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            btn_prev     <= 1'b1;
            held         <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            btn_prev     <= button_in;
            held         <= button_in;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= dclick_nxt;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) repeat_tick <= 1'b0;
        else       repeat_tick <= tick_nxt;
    end
`else
    assign repeat_tick = 1'b0;
    logic unused_tick;
    assign unused_tick = tick_nxt;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: hand-built vector table, then random gestures
// checked against a timestamp-based gesture model.
module tb_button_event_decoder;

    localparam int LONG = 20;
    localparam int DCLK = 10;
    localparam int REP  = 5;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_in = 1'b0;
    logic short_press, long_press, double_click, repeat_tick, held;

    button_event_decoder #(
        .LONG_CYCLES(LONG), .DCLICK_CYCLES(DCLK), .REPEAT_CYCLES(REP), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .button_in(button_in),
        .short_press(short_press), .long_press(long_press),
        .double_click(double_click), .repeat_tick(repeat_tick), .held(held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       b;
        logic [4:0] exp;   // {short, long, dclick, tick, held}
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic b, input logic s, input logic l,
                       input logic d, input logic t, input logic h);
        vec_t v;
        v.rst = r;
        v.b   = b;
        v.exp = {s, l, d, t, h};
        tbl.push_back(v);
    endtask

    task automatic add_run(input logic r, input logic b, input int n);
        for (int k = 0; k < n; k++) add(r, b, 1'b0, 1'b0, 1'b0, 1'b0, r ? 1'b0 : b);
    endtask

    task automatic apply(input logic r, input logic b, input logic [4:0] exp,
                         input string name, input int idx);
        logic [4:0] got;
        reset     = r;
        button_in = b;
        @(posedge clk);
        #1;
        got = {short_press, long_press, double_click, repeat_tick, held};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b want %b (short,long,dclick,tick,held)",
                     name, idx, got, exp);
        end
    endtask

    // Reference model: gesture phases tracked with timestamps of press/release/long.
    localparam int M_IDLE = 0, M_FIRST = 1, M_GAP = 2, M_SECOND = 3, M_LONG = 4;
    int   m_mode = M_IDLE;
    int   m_mark = 0;
    int   m_t = 0;
    logic m_prev = 1'b1;

    task automatic model_step(input logic r, input logic b, output logic [4:0] exp);
        logic s, l, d, tk;
        s = 0; l = 0; d = 0; tk = 0;
        if (r) begin
            m_mode = M_IDLE;
            m_prev = 1'b1;
            exp = 5'b0;
        end else begin
            if (m_mode == M_IDLE) begin
                if (b && !m_prev) begin m_mode = M_FIRST; m_mark = m_t; end
            end else if (m_mode == M_FIRST) begin
                if (b) begin
                    if (m_t - m_mark + 1 == LONG) begin l = 1; m_mode = M_LONG; m_mark = m_t; end
                end else begin
                    m_mode = M_GAP; m_mark = m_t;
                end
            end else if (m_mode == M_GAP) begin
                if (b) begin d = 1; m_mode = M_SECOND; end
                else if (m_t - m_mark + 1 == DCLK) begin s = 1; m_mode = M_IDLE; end
            end else if (m_mode == M_SECOND) begin
                if (!b) m_mode = M_IDLE;
            end else begin
                if (!b) m_mode = M_IDLE;
                else if (AR && ((m_t - m_mark) % REP == 0)) tk = 1;
            end
            m_prev = b;
            exp = {s, l, d, tk, b};
        end
        m_t++;
    endtask

    initial begin
        // Power-up reset, then idle so the first press is a genuine rise.
        add_run(1, 0, 2);
        add_run(0, 0, 2);
        // Short press: pulse on the 10th low sample after release.
        add_run(0, 1, 5); add_run(0, 0, 9); add(0, 0, 1, 0, 0, 0, 0); add_run(0, 0, 5);
        // Long press held 42 samples; ticks only with auto-repeat.
        add_run(0, 1, 19); add(0, 1, 0, 1, 0, 0, 1);
        for (int j = 1; j <= 22; j++) add(0, 1, 0, 0, 0, AR && (j % REP == 0), 1);
        add_run(0, 0, 15);
        // Double click, then no short even after a long idle.
        add_run(0, 1, 4); add_run(0, 0, 3); add(0, 1, 0, 0, 1, 0, 1);
        add_run(0, 1, 3); add_run(0, 0, 20);
        // Two presses separated by more than the window: two shorts.
        for (int k = 0; k < 2; k++) begin
            add_run(0, 1, 4); add_run(0, 0, 9); add(0, 0, 1, 0, 0, 0, 0); add_run(0, 0, 2);
        end
        // Second rise on the exact window-expiry cycle counts as double click.
        add_run(0, 1, 2); add_run(0, 0, 9); add(0, 1, 0, 0, 1, 0, 1);
        add_run(0, 1, 2); add_run(0, 0, 12);
        // Held through reset: nothing until released, then a normal short.
        add_run(1, 1, 3); add_run(0, 1, 40); add_run(0, 0, 5);
        add_run(0, 1, 3); add_run(0, 0, 9); add(0, 0, 1, 0, 0, 0, 0); add_run(0, 0, 3);
        // Reset during the double-click window discards the pending short.
        add_run(0, 1, 3); add_run(0, 0, 4); add_run(1, 0, 1); add_run(0, 0, 12);
        // Reset mid long-hold: everything stops, no events while still held.
        add_run(0, 1, 19); add(0, 1, 0, 1, 0, 0, 1); add_run(0, 1, 2);
        add_run(1, 1, 1); add_run(0, 1, 10); add_run(0, 0, 12);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].rst, tbl[i].b, tbl[i].exp, "table", i);

        // Random gestures against the model.
        begin
            logic [4:0] exp;
            logic       lvl;
            int         idx;
            idx = 0;
            lvl = 1'b0;
            model_step(1'b1, 1'b0, exp);
            apply(1'b1, 1'b0, exp, "rand_reset", idx++);
            for (int run = 0; run < 200; run++) begin
                int len;
                if ($urandom_range(0, 29) == 0) begin
                    logic rb;
                    rb = 1'($urandom_range(0, 1));
                    for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                        model_step(1'b1, rb, exp);
                        apply(1'b1, rb, exp, "rand_reset", idx++);
                    end
                end
                lvl = ~lvl;
                len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                                  : int'($urandom_range(7, 30));
                for (int k = 0; k < len; k++) begin
                    model_step(1'b0, lvl, exp);
                    apply(1'b0, lvl, exp, "random", idx++);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
